// File: rtl/pc_redirect_ctrl.sv
// Redirect sequencer in front of the IF-stage PC: arbitrates trap/ctxret/mret/jump,
// parks a redirect while fetch is busy and drives PC stall plus IF/ID flushes.
module pc_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            hazard_stall_i,
  input  logic            imem_ready_i,
  input  logic            je_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            system_ret_i,
  input  logic [XLEN-1:0] system_retaddr_i,
  input  logic            ctxret_i,
  input  logic [XLEN-1:0] ctxret_addr_i,
  input  logic            trap_taken_i,
  input  logic [XLEN-1:0] trap_entry_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_addr_o,
  output logic [1:0]      redir_src_o,
  output logic            stall_o,
  output logic            flush_if_o,
  output logic            flush_id_o,
  output logic            busy_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] SRC_JUMP   = 2'd0;
  localparam logic [1:0] SRC_MRET   = 2'd1;
  localparam logic [1:0] SRC_CTXRET = 2'd2;
  localparam logic [1:0] SRC_TRAP   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
  logic [1:0]        pend_src_q, pend_src_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              req_vld;
  logic [1:0]        req_src;
  logic [XLEN-1:0]   req_addr;
  logic              sel_vld;
  logic [1:0]        sel_src;
  logic [XLEN-1:0]   sel_addr;
  logic              issue;

  // Fixed-priority winner; during FLUSH the jump and mret sources are wrong-path.
  always_comb begin
    req_vld  = 1'b0;
    req_src  = SRC_JUMP;
    req_addr = '0;
    if (trap_taken_i) begin
      req_vld  = 1'b1;
      req_src  = SRC_TRAP;
      req_addr = trap_entry_i;
    end else if (ctxret_i) begin
      req_vld  = 1'b1;
      req_src  = SRC_CTXRET;
      req_addr = ctxret_addr_i;
    end else if (state_q != S_FLUSH && system_ret_i) begin
      req_vld  = 1'b1;
      req_src  = SRC_MRET;
      req_addr = system_retaddr_i;
    end else if (state_q != S_FLUSH && je_i) begin
      req_vld  = 1'b1;
      req_src  = SRC_JUMP;
      req_addr = jump_addr_i;
    end
  end

  // In HOLD only a strictly higher-priority source displaces the parked entry.
  always_comb begin
    sel_vld  = req_vld;
    sel_src  = req_src;
    sel_addr = req_addr;
    if (state_q == S_HOLD) begin
      sel_vld = 1'b1;
      if (!(req_vld && (req_src > pend_src_q))) begin
        sel_src  = pend_src_q;
        sel_addr = pend_addr_q;
      end
    end
    issue = sel_vld && imem_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pend_addr_q <= '0;
      pend_src_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_src_q  <= pend_src_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_src_d  = pend_src_q;
    flush_cnt_d = flush_cnt_q;
    if (issue) begin
      state_d     = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
      flush_cnt_d = CNT_INIT;
    end else if (sel_vld) begin
      state_d     = S_HOLD;
      pend_addr_d = sel_addr;
      pend_src_d  = sel_src;
    end else if (state_q == S_FLUSH) begin
      flush_cnt_d = flush_cnt_q - CNT_ONE;
      if (flush_cnt_q <= CNT_ONE) state_d = S_IDLE;
    end
  end

  // Outputs are forced quiet while reset is held, regardless of input activity.
  always_comb begin
    redir_valid_o = 1'b0;
    redir_addr_o  = '0;
    redir_src_o   = '0;
    stall_o       = 1'b0;
    flush_if_o    = 1'b0;
    flush_id_o    = 1'b0;
    busy_o        = 1'b0;
    if (rst_ni) begin
      if (state_q == S_HOLD) begin
        busy_o     = 1'b1;
        stall_o    = 1'b1;
        flush_if_o = 1'b1;
      end else begin
        stall_o    = hazard_stall_i;
        flush_if_o = (state_q == S_FLUSH);
        if (sel_vld) begin
          stall_o    = 1'b1;
          flush_if_o = 1'b1;
          flush_id_o = 1'b1;
        end
      end
      if (issue) begin
        redir_valid_o = 1'b1;
        redir_addr_o  = sel_addr;
        redir_src_o   = sel_src;
        stall_o       = 1'b0;
        flush_id_o    = 1'b1;
      end
    end
  end

endmodule
